// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle RV32I control FSM that sequences a shared datapath (register
// file, ALU, PC, IR). Instruction and data memories are reached through
// valid/ready handshakes, so their latency is allowed to vary. An optional
// multi-cycle M-extension unit is supported through alu_busy.
//
// Parameters
//   ENABLE_M     1 = OP with funct7=0000001 is an M-ext op (waits on alu_busy)
//                0 = such encodings trap as illegal
//   MEM_TIMEOUT  max cycles spent in any memory wait state before trapping;
//                0 disables the timeout
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req_valid/ready          instruction fetch request handshake
//   imem_rsp_valid/data           instruction fetch response
//   dmem_req_valid/we/ready       load/store request handshake (we=1 store)
//   dmem_rsp_valid                load data response
//   alu_busy                      M-ext unit still computing
//   ir_en, pc_en                  IR latch enable, PC update enable
//   RF_rsel1/2, RF_wsel, RF_wen   register file selects and write enable
//   RF_wdata_sel                  00 ALU, 01 DM, 10 PC+4
//   ALU_OP1_SEL                   0 REG, 1 PC
//   ALU_OP2_SEL                   0 REG, 1 IMM
//   ALU_Operation                 ADD..AND, MEXT (codes below)
//   branch_condition              funct3 for branches, else 000
//   retire                        one-cycle pulse per completed instruction
//   trap, trap_cause              sticky trap flag and its cause
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int ENABLE_M    = 0,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dmem_req_valid,
    output logic        dmem_req_we,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    input  logic        alu_busy,
    output logic        ir_en,
    output logic        pc_en,
    output logic [4:0]  RF_rsel1,
    output logic [4:0]  RF_rsel2,
    output logic [4:0]  RF_wsel,
    output logic        RF_wen,
    output logic [1:0]  RF_wdata_sel,
    output logic        ALU_OP1_SEL,
    output logic        ALU_OP2_SEL,
    output logic [3:0]  ALU_Operation,
    output logic [2:0]  branch_condition,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_MEXT = 4'd10;

    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_PC  = 1'b1;
    localparam logic SEL_IMM = 1'b1;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    // Width kept at least 1 so a disabled timeout still elaborates cleanly.
    localparam int CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int TMO_LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LIMIT);

    typedef enum logic [3:0] {
        S_BOOT, S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXEC,
        S_MEM, S_MEM_WAIT, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC
    } class_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;

    // Fields of the registered instruction.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    class_t     cls;
    logic       is_mop;
    logic [3:0] alu_op_dec;
    logic [4:0] rsel1_dec, rsel2_dec;
    logic       op1_dec, op2_dec;
    logic       tmo_hit, in_wait;

    // Decode of the registered instruction; only consulted from DECODE on.
    always_comb begin
        is_mop     = (opcode == OPC_OP) && (funct7 == 7'b0000001);
        cls        = C_NONE;
        alu_op_dec = ALU_ADD;
        case (opcode)
            OPC_OP:     cls = (is_mop && (ENABLE_M == 0)) ? C_NONE : C_OP;
            OPC_OPIMM:  cls = C_OPIMM;
            OPC_LOAD:   cls = C_LOAD;
            OPC_STORE:  cls = C_STORE;
            OPC_BRANCH: cls = C_BRANCH;
            OPC_JAL:    cls = C_JAL;
            OPC_JALR:   cls = C_JALR;
            OPC_LUI:    cls = C_LUI;
            OPC_AUIPC:  cls = C_AUIPC;
            default:    cls = C_NONE;
        endcase

        if (cls == C_OP || cls == C_OPIMM) begin
            case (funct3)
                3'b000:  alu_op_dec = (cls == C_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op_dec = ALU_SLL;
                3'b010:  alu_op_dec = ALU_SLT;
                3'b011:  alu_op_dec = ALU_SLTU;
                3'b100:  alu_op_dec = ALU_XOR;
                3'b101:  alu_op_dec = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op_dec = ALU_OR;
                default: alu_op_dec = ALU_AND;
            endcase
            if (cls == C_OP && is_mop) begin
                alu_op_dec = ALU_MEXT;
            end
        end

        rsel1_dec = (cls == C_LUI) ? 5'd0 : rs1;
        rsel2_dec = (cls == C_OP || cls == C_STORE || cls == C_BRANCH) ? rs2 : 5'd0;
        op1_dec   = (cls == C_AUIPC || cls == C_JAL || cls == C_BRANCH) ? SEL_PC : SEL_REG;
        op2_dec   = (cls == C_OP) ? SEL_REG : SEL_IMM;
    end

    assign tmo_hit = (MEM_TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST);
    assign in_wait = (state_q == S_FETCH) || (state_q == S_FETCH_WAIT) ||
                     (state_q == S_MEM)   || (state_q == S_MEM_WAIT);

    // Next state and control outputs. A handshake is tested before the
    // timeout so a same-cycle handshake always wins over the trap.
    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        trap_d           = trap_q;
        cause_d          = cause_q;
        imem_req_valid   = 1'b0;
        dmem_req_valid   = 1'b0;
        dmem_req_we      = 1'b0;
        ir_en            = 1'b0;
        pc_en            = 1'b0;
        RF_rsel1         = 5'd0;
        RF_rsel2         = 5'd0;
        RF_wsel          = 5'd0;
        RF_wen           = 1'b0;
        RF_wdata_sel     = 2'b00;
        ALU_OP1_SEL      = 1'b0;
        ALU_OP2_SEL      = 1'b0;
        ALU_Operation    = 4'd0;
        branch_condition = 3'b000;
        retire           = 1'b0;

        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = S_FETCH_WAIT;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_IMEM;
                end
            end
            S_FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    ir_en   = 1'b1;
                    ir_d    = imem_rsp_data;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                RF_rsel1 = rsel1_dec;
                RF_rsel2 = rsel2_dec;
                if (cls == C_NONE) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                RF_rsel1      = rsel1_dec;
                RF_rsel2      = rsel2_dec;
                ALU_OP1_SEL   = op1_dec;
                ALU_OP2_SEL   = op2_dec;
                ALU_Operation = alu_op_dec;
                if (cls == C_BRANCH) begin
                    branch_condition = funct3;
                end
                if (alu_op_dec == ALU_MEXT && alu_busy) begin
                    state_d = S_EXEC;
                end else if (cls == C_LOAD || cls == C_STORE) begin
                    state_d = S_MEM;
                end else if (cls == C_BRANCH) begin
                    pc_en   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                RF_rsel1       = rsel1_dec;
                RF_rsel2       = rsel2_dec;
                dmem_req_valid = 1'b1;
                dmem_req_we    = (cls == C_STORE);
                if (dmem_req_ready) begin
                    if (cls == C_STORE) begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_MEM_WAIT;
                    end
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_DMEM;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_rsp_valid) begin
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_DMEM;
                end
            end
            S_WB: begin
                pc_en   = 1'b1;
                retire  = 1'b1;
                RF_wsel = rd;
                RF_wen  = (rd != 5'd0);
                if (cls == C_LOAD) begin
                    RF_wdata_sel = 2'b01;
                end else if (cls == C_JAL || cls == C_JALR) begin
                    RF_wdata_sel = 2'b10;
                end
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_BOOT;
        endcase

        trap       = trap_q;
        trap_cause = cause_q;
    end

    // Timeout counter restarts on every state change, so each wait state
    // gets its own full budget.
    always_comb begin
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (in_wait) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_BOOT;
            ir_q      <= 32'd0;
            tmo_cnt_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            tmo_cnt_q <= tmo_cnt_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench. Two instances share every input:
//   dut   ENABLE_M=1, MEM_TIMEOUT=8
//   dut_b ENABLE_M=0, MEM_TIMEOUT=0 (M-ops illegal, no timeout)
// Inputs change just after the falling edge and outputs are sampled 1 time
// unit later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MEXT = 4'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_rsp_valid = 1'b0;
    logic        alu_busy = 1'b0;

    logic        imem_req_valid, dmem_req_valid, dmem_req_we, ir_en, pc_en;
    logic [4:0]  RF_rsel1, RF_rsel2, RF_wsel;
    logic        RF_wen, ALU_OP1_SEL, ALU_OP2_SEL, retire, trap;
    logic [1:0]  RF_wdata_sel, trap_cause;
    logic [3:0]  ALU_Operation;
    logic [2:0]  branch_condition;

    logic        b_imem_req_valid, b_dmem_req_valid, b_dmem_req_we, b_ir_en, b_pc_en;
    logic [4:0]  b_RF_rsel1, b_RF_rsel2, b_RF_wsel;
    logic        b_RF_wen, b_ALU_OP1_SEL, b_ALU_OP2_SEL, b_retire, b_trap;
    logic [1:0]  b_RF_wdata_sel, b_trap_cause;
    logic [3:0]  b_ALU_Operation;
    logic [2:0]  b_branch_condition;

    logic [35:0] all_a, all_b;
    assign all_a = {imem_req_valid, dmem_req_valid, dmem_req_we, ir_en, pc_en,
                    RF_rsel1, RF_rsel2, RF_wsel, RF_wen, RF_wdata_sel,
                    ALU_OP1_SEL, ALU_OP2_SEL, ALU_Operation, branch_condition,
                    retire, trap, trap_cause};
    assign all_b = {b_imem_req_valid, b_dmem_req_valid, b_dmem_req_we, b_ir_en, b_pc_en,
                    b_RF_rsel1, b_RF_rsel2, b_RF_wsel, b_RF_wen, b_RF_wdata_sel,
                    b_ALU_OP1_SEL, b_ALU_OP2_SEL, b_ALU_Operation, b_branch_condition,
                    b_retire, b_trap, b_trap_cause};

    always #5 clk = ~clk;

    multicycle_control_unit #(.ENABLE_M(1), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_we(dmem_req_we),
        .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
        .alu_busy(alu_busy), .ir_en(ir_en), .pc_en(pc_en),
        .RF_rsel1(RF_rsel1), .RF_rsel2(RF_rsel2), .RF_wsel(RF_wsel),
        .RF_wen(RF_wen), .RF_wdata_sel(RF_wdata_sel),
        .ALU_OP1_SEL(ALU_OP1_SEL), .ALU_OP2_SEL(ALU_OP2_SEL),
        .ALU_Operation(ALU_Operation), .branch_condition(branch_condition),
        .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    multicycle_control_unit #(.ENABLE_M(0), .MEM_TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req_valid(b_imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dmem_req_valid(b_dmem_req_valid), .dmem_req_we(b_dmem_req_we),
        .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
        .alu_busy(alu_busy), .ir_en(b_ir_en), .pc_en(b_pc_en),
        .RF_rsel1(b_RF_rsel1), .RF_rsel2(b_RF_rsel2), .RF_wsel(b_RF_wsel),
        .RF_wen(b_RF_wen), .RF_wdata_sel(b_RF_wdata_sel),
        .ALU_OP1_SEL(b_ALU_OP1_SEL), .ALU_OP2_SEL(b_ALU_OP2_SEL),
        .ALU_Operation(b_ALU_Operation), .branch_condition(b_branch_condition),
        .retire(b_retire), .trap(b_trap), .trap_cause(b_trap_cause)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Ends during the first FETCH cycle after reset release.
    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; alu_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_outs", 64'(all_a), 64'd0);
        check("reset_outs_b", 64'(all_b), 64'd0);
        rst = 1'b0;
        #1 check("boot_idle", 64'(imem_req_valid), 64'd0);
        @(negedge clk);
        #1 check("boot_to_fetch", 64'(imem_req_valid), 64'd1);
    endtask

    // Called during a FETCH cycle; returns during the DECODE cycle.
    task automatic fetch_instr(input string nm, input logic [31:0] ins);
        imem_req_ready = 1'b1;
        #1 check({nm, "_fetch_req"}, 64'(imem_req_valid), 64'd1);
        @(negedge clk);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = ins;
        #1 check({nm, "_ir_en"}, 64'({imem_req_valid, ir_en}), 64'b01);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1 check({nm, "_decode_quiet"}, 64'({imem_req_valid, ir_en, retire}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // ADDI x1,x0,5
        fetch_instr("addi", 32'h00500093);
        @(negedge clk); #1;
        check("addi_exec_aluop", 64'(ALU_Operation), 64'(ALU_ADD));
        check("addi_exec_op2", 64'(ALU_OP2_SEL), 64'd1);
        check("addi_exec_retire", 64'({retire, RF_wen}), 64'd0);
        @(negedge clk); #1;
        check("addi_wb_ctl", 64'({retire, pc_en, RF_wen}), 64'b111);
        check("addi_wb_wsel", 64'(RF_wsel), 64'd1);
        check("addi_wb_wdsel", 64'(RF_wdata_sel), 64'd0);
        @(negedge clk); #1 check("addi_next_fetch", 64'({imem_req_valid, retire}), 64'b10);
        $display("[TB] ADDI x1,x0,5 retired");

        // LW x2,0(x1) with dmem stalling three cycles
        fetch_instr("lw", 32'h0000A103);
        @(negedge clk); #1;
        check("lw_exec_rsel1", 64'(RF_rsel1), 64'd1);
        check("lw_exec_rsel2", 64'(RF_rsel2), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); dmem_req_ready = 1'b0;
            #1 check("lw_mem_stall", 64'({dmem_req_valid, dmem_req_we, retire}), 64'b100);
        end
        @(negedge clk); dmem_req_ready = 1'b1;
        #1 check("lw_mem_hs", 64'({dmem_req_valid, dmem_req_we, retire, pc_en}), 64'b1000);
        @(negedge clk); dmem_req_ready = 1'b0;
        #1 check("lw_wait_idle", 64'({dmem_req_valid, retire, RF_wen}), 64'd0);
        @(negedge clk); dmem_rsp_valid = 1'b1;
        #1 check("lw_wait_rsp", 64'({retire, RF_wen}), 64'd0);
        @(negedge clk); dmem_rsp_valid = 1'b0;
        #1 check("lw_wb_ctl", 64'({retire, pc_en, RF_wen}), 64'b111);
        check("lw_wb_wdsel", 64'(RF_wdata_sel), 64'd1);
        check("lw_wb_wsel", 64'(RF_wsel), 64'd2);
        @(negedge clk); #1 check("lw_next_fetch", 64'(imem_req_valid), 64'd1);
        $display("[TB] LW x2,0(x1) retired");

        // SW x2,4(x1)
        fetch_instr("sw", 32'h0020A223);
        @(negedge clk); #1;
        check("sw_exec_rsel2", 64'(RF_rsel2), 64'd2);
        check("sw_exec_quiet", 64'({retire, RF_wen}), 64'd0);
        @(negedge clk); dmem_req_ready = 1'b1;
        #1 check("sw_mem_hs", 64'({dmem_req_valid, dmem_req_we, retire, pc_en, RF_wen}), 64'b11110);
        @(negedge clk); dmem_req_ready = 1'b0;
        #1 check("sw_next_fetch", 64'({imem_req_valid, dmem_req_valid, RF_wen}), 64'b100);
        $display("[TB] SW x2,4(x1) retired");

        // ADD x0,x1,x2: write to x0 suppressed
        fetch_instr("add", 32'h00208033);
        @(negedge clk); #1;
        check("add_exec_ops", 64'({ALU_OP1_SEL, ALU_OP2_SEL, ALU_Operation}), 64'({1'b0, 1'b0, ALU_ADD}));
        check("add_exec_rsel", 64'({RF_rsel1, RF_rsel2}), 64'({5'd1, 5'd2}));
        @(negedge clk); #1 check("add_wb_x0", 64'({retire, pc_en, RF_wen}), 64'b110);
        @(negedge clk); #1;
        $display("[TB] ADD x0,x1,x2 retired");

        // SUB x3,x1,x2
        fetch_instr("sub", 32'h402081B3);
        @(negedge clk); #1 check("sub_exec_aluop", 64'(ALU_Operation), 64'(ALU_SUB));
        @(negedge clk); #1 check("sub_wb", 64'({retire, RF_wen, RF_wsel}), 64'({2'b11, 5'd3}));
        @(negedge clk); #1;
        $display("[TB] SUB x3,x1,x2 retired");

        // BNE x1,x2,+8: retires from EXEC
        fetch_instr("bne", 32'h00209463);
        @(negedge clk); #1;
        check("bne_exec_cond", 64'(branch_condition), 64'd1);
        check("bne_exec_ctl", 64'({ALU_OP1_SEL, retire, pc_en, RF_wen}), 64'b1110);
        @(negedge clk); #1 check("bne_next_fetch", 64'({imem_req_valid, retire}), 64'b10);
        $display("[TB] BNE x1,x2,+8 retired");

        // JAL x1,0: link value from PC+4
        fetch_instr("jal", 32'h000000EF);
        @(negedge clk); #1 check("jal_exec_sel", 64'({ALU_OP1_SEL, ALU_OP2_SEL}), 64'b11);
        @(negedge clk); #1;
        check("jal_wb_wdsel", 64'(RF_wdata_sel), 64'd2);
        check("jal_wb_ctl", 64'({retire, RF_wen, RF_wsel}), 64'({2'b11, 5'd1}));
        @(negedge clk); #1;
        $display("[TB] JAL x1,0 retired");

        // MUL x3,x1,x2: dut holds EXEC while busy, dut_b traps as illegal
        fetch_instr("mul", 32'h022081B3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); alu_busy = 1'b1;
            #1 check("mul_exec_busy", 64'({ALU_Operation, retire}), 64'({ALU_MEXT, 1'b0}));
            if (i == 0) begin
                check("mul_b_trap", 64'({b_trap, b_trap_cause, b_imem_req_valid}), 64'b1010);
            end
        end
        @(negedge clk); alu_busy = 1'b0;
        #1 check("mul_exec_done", 64'({ALU_Operation, retire}), 64'({ALU_MEXT, 1'b0}));
        @(negedge clk); #1;
        check("mul_wb", 64'({retire, RF_wen, RF_wsel}), 64'({2'b11, 5'd3}));
        check("mul_b_still_trap", 64'({b_trap, b_retire, b_pc_en, b_RF_wen}), 64'b1000);
        $display("[TB] MUL x3,x1,x2 retired (dut), trapped (dut_b)");

        // All-zero instruction is illegal
        do_reset();
        fetch_instr("illegal", 32'h00000000);
        @(negedge clk); #1 check("illegal_trap", 64'({trap, trap_cause, imem_req_valid}), 64'b1010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); imem_req_ready = 1'b1;
            #1 check("illegal_no_fetch", 64'({imem_req_valid, pc_en, trap}), 64'b001);
        end
        imem_req_ready = 1'b0;
        $display("[TB] 0x00000000 trapped as illegal");

        // Asynchronous reset in the middle of EXEC
        do_reset();
        fetch_instr("rst_addi", 32'h00500093);
        @(negedge clk); #1 check("rst_exec_live", 64'(ALU_OP2_SEL), 64'd1);
        #1 rst = 1'b1;
        #1 check("rst_async_outs", 64'(all_a), 64'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("rst_boot", 64'(imem_req_valid), 64'd0);
        @(negedge clk); #1 check("rst_fetch", 64'(imem_req_valid), 64'd1);
        $display("[TB] async reset mid-EXEC recovered");

        // Fetch timeout: ready held low, trap after the 8th FETCH cycle
        do_reset();
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk); #1 check("tmo_fetch_wait", 64'({imem_req_valid, trap}), 64'b10);
        end
        @(negedge clk); #1;
        check("tmo_fetch_trap", 64'({trap, trap_cause, imem_req_valid}), 64'b1100);
        check("tmo_b_no_trap", 64'({b_trap, b_imem_req_valid}), 64'b01);
        $display("[TB] imem timeout trapped");

        // Handshake on the 8th cycle wins; then a dmem timeout on LW
        do_reset();
        for (int i = 2; i <= 7; i++) begin
            @(negedge clk); #1;
        end
        @(negedge clk); imem_req_ready = 1'b1;
        #1 check("tmo_edge_req", 64'({imem_req_valid, trap}), 64'b10);
        @(negedge clk); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000A103;
        #1 check("tmo_edge_fw", 64'({trap, imem_req_valid, ir_en}), 64'b001);
        @(negedge clk); imem_rsp_valid = 1'b0;
        @(negedge clk); #1 check("tmo_lw_exec", 64'(RF_rsel1), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1 check("tmo_mem_wait", 64'({dmem_req_valid, trap}), 64'b10);
        end
        @(negedge clk); #1;
        check("tmo_dmem_trap", 64'({trap, trap_cause, dmem_req_valid}), 64'b1110);
        check("tmo_b_in_mem", 64'({b_trap, b_dmem_req_valid}), 64'b01);
        $display("[TB] dmem timeout trapped");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle RV32I decoder.
- Drives a shared datapath (register file, ALU, PC, IR) through an explicit multi-cycle FSM.
- Uses valid/ready handshakes to instruction and data memory, so variable-latency memories and an optional multi-cycle M-extension unit are supported.
- Decodes JALR as its own class, suppresses writes to x0, traps on illegal opcodes and memory timeouts.

Parameters:
- ENABLE_M, 0, 1 = decode OP/funct7=0000001 as M-ext; ALU_Operation=ALU_MEXT; EXEC waits on alu_busy. 0 = such encodings are illegal.
- MEM_TIMEOUT, 0, maximum wait cycles in any memory wait state before trap. 0 disables the timeout. Counter width is $clog2(MEM_TIMEOUT+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  imem accepts request
- imem_rsp_valid  in  1  fetch data valid
- imem_rsp_data  in  32  fetched instruction
- dmem_req_valid  out  1  load/store request
- dmem_req_we  out  1  1 = store
- dmem_req_ready  in  1  dmem accepts request
- dmem_rsp_valid  in  1  load data valid
- alu_busy  in  1  M-ext unit still computing
- ir_en  out  1  latch instruction register
- pc_en  out  1  update PC (next-PC mux in datapath)
- RF_rsel1, RF_rsel2  out  5  register read selects
- RF_wsel  out  5  rd
- RF_wen  out  1  register-file write enable
- RF_wdata_sel  out  2  00 ALU, 01 DM, 10 PC+4
- ALU_OP1_SEL, ALU_OP2_SEL  out  1  team ALU operand-select codes
- ALU_Operation  out  4  team ALU opcode codes
- branch_condition  out  3  funct3 when B-type, else 000
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky; set on illegal instruction or timeout
- trap_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout

Behaviour:
- Reset (async, any state): state=BOOT, all outputs 0, IR-derived decode registers 0, timeout counter 0.
- States: BOOT, FETCH, FETCH_WAIT, DECODE, EXEC, MEM, MEM_WAIT, WB, TRAP.
- BOOT: 1 cycle, then FETCH.
- FETCH: imem_req_valid=1. On imem_req_valid&imem_req_ready go to FETCH_WAIT.
- FETCH_WAIT: on imem_rsp_valid, ir_en=1 for that cycle, capture imem_rsp_data into the internal decode register, go to DECODE.
- DECODE: 1 cycle.
  - Classify by opcode [6:0]: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode sets trap, trap_cause=01 and goes to TRAP.
- EXEC: ALU controls valid.
  - If ENABLE_M and M-op, remain while alu_busy=1.
  - LOAD/STORE go to MEM.
  - BRANCH: pc_en=1, retire=1, go to FETCH; the datapath resolves taken/not-taken.
  - All other classes go to WB.
- MEM: dmem_req_valid=1, dmem_req_we = (class==STORE). On handshake:
  - store: pc_en=1, retire=1, go to FETCH;
  - load: go to MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid go to WB.
- WB: 1 cycle. pc_en=1, retire=1.
  - RF_wen = (rd != 0).
  - RF_wdata_sel: DM for LOAD, PC+4 for JAL/JALR, ALU otherwise.
  - Next state FETCH.
- TRAP: terminal. No requests, no pc_en/RF_wen; exit only via reset.
- Operand selects:
  - ALU_OP1_SEL = PC for AUIPC/JAL/BRANCH; REG otherwise. LUI uses rsel1=0.
  - ALU_OP2_SEL = REG for OP; IMM otherwise.
  - rsel2 = rs2 only for OP/STORE/BRANCH; else 0.
- ALU_Operation:
  - OP-IMM uses funct7 only for SRLI/SRAI.
  - OP uses funct7 for ADD/SUB and SRL/SRA.
  - All other classes use ADD.
- Timeout: counter clears on entry to any wait state (FETCH, FETCH_WAIT, MEM, MEM_WAIT) and increments each waiting cycle. On reaching MEM_TIMEOUT:
  - go to TRAP;
  - cause 10 for fetch states, 11 for mem states.
- Simultaneous events: a handshake in the same cycle the counter hits its limit wins; no trap.
- Control outputs are combinational from state plus the registered decode. The datapath samples them at the clock edge.
- Outside the listed states, control outputs are 0.

Test Plan:
- ADDI x1,x0,5 (0x00500093), imem ready=1, rsp 1 cycle later: FETCH, FETCH_WAIT, DECODE, EXEC, WB. retire on cycle 5, RF_wen=1, RF_wsel=1, RF_wdata_sel=00, ALU_Operation=ADD, OP2=IMM.
- LW x2,0(x1) (0x0000A103), dmem ready held 0 for 3 cycles: dmem_req_valid stays 1 through MEM, dmem_req_we=0. WB only after dmem_rsp_valid. RF_wdata_sel=01, RF_wen=1.
- SW x2,4(x1) (0x0020A223): dmem_req_we=1. retire and pc_en pulse in the MEM handshake cycle. RF_wen never asserted.
- ADD x0,x1,x2 (0x00208033): reaches WB with retire=1, RF_wen=0. MUL 0x022081B3 with ENABLE_M=1 and alu_busy=1 for 4 cycles: EXEC held 4 extra cycles. Same MUL with ENABLE_M=0: trap=1, cause=01.
- Instruction 0x00000000: TRAP, cause 01, no further imem_req_valid. Assert rst mid-EXEC of another run: all outputs 0 immediately; BOOT then FETCH after release.
- MEM_TIMEOUT=8, imem_req_ready tied 0: TRAP after 8 FETCH cycles, cause 10. Ready asserted on the 8th cycle: no trap, proceeds to FETCH_WAIT.
